// File: rtl/fft_mag_squared_pkg.sv
// Shared constants for the FFT magnitude-squared datapath.
//   FFT_W_DEFAULT : default width of one signed FFT component
//   sq_w / sum_w  : derived widths of a square (2W) and of the power sum (2W+1)
package fft_mag_squared_pkg;

  localparam int unsigned FFT_W_DEFAULT = 16;

  function automatic int unsigned sq_w(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned sum_w(input int unsigned w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/fft_sq_stage.sv
// Registered signed squarer: sq = din * din, loaded every cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low clear of the product register
//   din   : W-bit two's-complement operand
//   sq    : 2W-bit non-negative square (registered)
module fft_sq_stage #(
  parameter int unsigned W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] din,
  output logic [2*W-1:0]      sq
);

  localparam int unsigned SW = 2 * W;

  logic signed [SW-1:0] din_ext;
  logic signed [SW-1:0] prod;

  // Sign-extend to the product width so the multiply is a plain signed square.
  assign din_ext = SW'(din);
  assign prod    = din_ext * din_ext;

  // Multiply alone in this stage so it maps cleanly onto a DSP block.
  always_ff @(posedge clk) begin
    if (!reset) sq <= '0;
    else        sq <= SW'(prod);
  end

endmodule

// File: rtl/fft_mag_squared.sv
// Streaming |X|^2 = real^2 + imag^2 for complex FFT bins, two-cycle latency,
// one sample per clock, no back-pressure.
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-low; flushes the pipeline
//   fft_valid : qualifies fft_real / fft_imag
//   fft_real  : signed real part (W bits)
//   fft_imag  : signed imaginary part (W bits)
//   mag_sq    : unsigned power (2W+1 bits), holds between valid results
//   mag_valid : mag_sq carries a new result this cycle
module fft_mag_squared
  import fft_mag_squared_pkg::*;
#(
  parameter int unsigned W = FFT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fft_valid,
  input  logic signed [W-1:0]   fft_real,
  input  logic signed [W-1:0]   fft_imag,
  output logic [sum_w(W)-1:0]   mag_sq,
  output logic                  mag_valid
);

  localparam int unsigned SW = sq_w(W);
  localparam int unsigned MW = sum_w(W);

  logic [SW-1:0] sq_re;
  logic [SW-1:0] sq_im;
  logic          v1;

  // Stage 1: both squarers and the valid bit.
  fft_sq_stage #(.W(W)) u_sq_re (
    .clk   (clk),
    .reset (reset),
    .din   (fft_real),
    .sq    (sq_re)
  );

  fft_sq_stage #(.W(W)) u_sq_im (
    .clk   (clk),
    .reset (reset),
    .din   (fft_imag),
    .sq    (sq_im)
  );

  always_ff @(posedge clk) begin
    if (!reset) v1 <= 1'b0;
    else        v1 <= fft_valid;
  end

  // Stage 2: unsigned sum of the two squares; the extra bit absorbs the
  // single worst case 2 * 2^(2W-2), so no overflow is possible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mag_sq    <= '0;
      mag_valid <= 1'b0;
    end else begin
      mag_valid <= v1;
      if (v1) mag_sq <= MW'(sq_re) + MW'(sq_im);
    end
  end

endmodule

// File: tb/tb_fft_mag_squared.sv
// Scoreboard bench for fft_mag_squared: the driver pushes hand-computed
// expected results tagged with the cycle they are due; a negedge monitor
// checks every cycle (valid pulse, value, hold and reset clearing).
module tb_fft_mag_squared;

  localparam int unsigned W  = 16;
  localparam int unsigned MW = 2 * W + 1;

  typedef struct {
    int unsigned    due;
    logic [MW-1:0]  val;
  } exp_t;

  logic                clk;
  logic                reset;
  logic                fft_valid;
  logic signed [W-1:0] fft_real;
  logic signed [W-1:0] fft_imag;
  logic [MW-1:0]       mag_sq;
  logic                mag_valid;

  exp_t          sb_q[$];
  int unsigned   cyc;
  bit            out_cleared;
  logic [MW-1:0] last_val;
  int            errors;
  int            checks;

  fft_mag_squared #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .fft_valid (fft_valid),
    .fft_real  (fft_real),
    .fft_imag  (fft_imag),
    .mag_sq    (mag_sq),
    .mag_valid (mag_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter; a reset edge discards everything in flight.
  always @(posedge clk) begin
    cyc++;
    out_cleared = !reset;
    if (!reset) sb_q.delete();
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (out_cleared) begin
        check("reset_valid", MW'(mag_valid), '0);
        check("reset_mag", mag_sq, '0);
        last_val = '0;
      end else if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        check("valid_pulse", MW'(mag_valid), MW'(1));
        check("mag_value", mag_sq, sb_q[0].val);
        last_val = sb_q[0].val;
        void'(sb_q.pop_front());
      end else begin
        check("no_pulse", MW'(mag_valid), '0);
        check("hold_mag", mag_sq, last_val);
      end
    end
  end

  // Drive one cycle of inputs; a valid sample with reset high is expected
  // two cycles later.
  task automatic drive(input logic rst, input logic v,
                       input int re, input int im, input logic [MW-1:0] exp_val);
    @(posedge clk);
    #1;
    reset     = rst;
    fft_valid = v;
    fft_real  = W'(re);
    fft_imag  = W'(im);
    if (v && rst) sb_q.push_back('{due: cyc + 2, val: exp_val});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 0, '0);
  endtask

  int re_t[10]  = '{23964, -7964, -28996, -28, 29011, 32225, -3198, 5685, -21674, 16884};
  int im_t[10]  = '{29636, -11006, -31880, -24906, -3145, 5921, -20539, -158, -14062, 15357};
  longint ex_t[10] = '{1452565792, 184557332, 1857102416, 620309620, 851529146,
                       1073508866, 432077725, 32344189, 667502120, 520906905};

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    last_val  = '0;
    reset     = 1'b0;
    fft_valid = 1'b0;
    fft_real  = '0;
    fft_imag  = '0;

    // Reset hold with random valid traffic.
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), '0);

    idle(2);

    // Back-to-back streaming vectors.
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b1, re_t[i], im_t[i], MW'(ex_t[i]));
    idle(3);

    // Extremes.
    drive(1'b1, 1'b1, -32768, -32768, MW'(64'd2147483648));
    drive(1'b1, 1'b1, 32767, 0, MW'(64'd1073676289));
    drive(1'b1, 1'b1, 0, 0, '0);
    idle(3);

    // Alternating valid; invalid cycles carry junk that must not appear.
    drive(1'b1, 1'b1, 3, 4, MW'(25));
    drive(1'b1, 1'b0, 1000, 1000, '0);
    drive(1'b1, 1'b1, -5, 12, MW'(169));
    drive(1'b1, 1'b0, -7, 7, '0);
    drive(1'b1, 1'b1, 100, -100, MW'(20000));
    drive(1'b1, 1'b0, 9, 9, '0);
    idle(3);

    // Mid-stream reset: two valid samples, reset asserted right behind them.
    drive(1'b1, 1'b1, 1000, 2000, MW'(5000000));
    drive(1'b0, 1'b1, 300, 400, MW'(250000));
    drive(1'b0, 1'b0, 0, 0, '0);
    drive(1'b1, 1'b1, -6, -8, MW'(100));
    idle(4);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 results outstanding", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
